br_redirect_ctrl: RTL

BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

---
 rtl/br_redirect_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/br_redirect_ctrl.sv
// Branch redirect controller: takes resolved branches from EXU, flushes younger work, drains IFU, redirects fetch.
// Latency: taken branch at T -> flush at T+1 -> redir_valid at T+2 at the earliest (longer while the IFU drains).
// Backpressure: redir_valid/redir_pc are held until redir_ready; exu_stall blocks new branches until then.
module br_redirect_ctrl #(
  parameter int XLEN     = 64,
  parameter int CNT_W    = 32,
  parameter int DRAIN_TO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             ifu_busy,
  input  logic             redir_ready,
  output logic             flush,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic             exu_stall,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             drain_err
);

  // Drain counter is wide enough to hold DRAIN_TO itself.
  localparam int DW = $clog2(DRAIN_TO + 2);
  // Count value on the last busy DRAIN cycle; the next edge reaches DRAIN_TO.
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TO - 1);
  // Redirect targets are halfword aligned, so bit 0 is always cleared.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] drain_cnt;

  // Single FSM: state, registered control outputs, statistics and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      flush       <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      exu_stall   <= 1'b0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
      drain_err   <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Only IDLE accepts resolutions; everywhere else br_valid is dropped.
          if (br_valid) begin
            br_cnt <= br_cnt + 1'b1;
            if (br_taken) begin
              taken_cnt <= taken_cnt + 1'b1;
              redir_pc  <= br_target & PC_ALIGN_MASK;
              state     <= S_FLUSH;
              flush     <= 1'b1;
              exu_stall <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          flush     <= 1'b0;
          drain_cnt <= '0;
          if (ifu_busy) begin
            state <= S_DRAIN;
          end else begin
            state       <= S_REDIR;
            redir_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!ifu_busy) begin
            state       <= S_REDIR;
            redir_valid <= 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            // IFU never went quiet: redirect anyway and record it.
            drain_cnt   <= drain_cnt + 1'b1;
            state       <= S_REDIR;
            redir_valid <= 1'b1;
            drain_err   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_REDIR: begin
          if (redir_ready) begin
            state       <= S_IDLE;
            redir_valid <= 1'b0;
            exu_stall   <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          flush       <= 1'b0;
          redir_valid <= 1'b0;
          exu_stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule
